// File: rtl/cardinal_nic_pkg.sv
// cardinal_nic_pkg: NIC address map, data width and arbiter state encoding
package cardinal_nic_pkg;
  localparam int DATA_W = 64;
  localparam logic [1:0] NIC_ADDR_IN_DATA  = 2'b00;
  localparam logic [1:0] NIC_ADDR_IN_STAT  = 2'b01;
  localparam logic [1:0] NIC_ADDR_OUT_DATA = 2'b10;
  localparam logic [1:0] NIC_ADDR_OUT_STAT = 2'b11;
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] POLL  = 3'd1;
  localparam logic [2:0] CHECK = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] READ  = 3'd4;
  localparam logic [2:0] RDATA = 3'd5;
endpackage

// File: rtl/cardinal_nic_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first request at or after ptr_i
module rr_pick #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  logic [IW-1:0] j;
  always_comb begin
    idx_o = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr_i) + k) % N);
      if (req_i[j]) idx_o = j;
    end
  end
  assign any_o = |req_i;
endmodule

// File: rtl/cardinal_nic_arbiter.sv
// cardinal_nic_arbiter: round-robin sharing of the NIC processor port,
// running the status-poll-then-access sequence for the granted requester.
module cardinal_nic_arbiter #(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = cardinal_nic_pkg::DATA_W,
  parameter int POLL_MAX = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        req_wr,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        done,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    busy,
  output logic [1:0]              addr,
  output logic [DATA_W-1:0]       d_in,
  output logic                    nicEn,
  output logic                    nicEnWr,
  input  logic [DATA_W-1:0]       d_out
);
  import cardinal_nic_pkg::*;
  localparam int IW = $clog2(N_REQ);
  localparam int PW = POLL_MAX > 1 ? $clog2(POLL_MAX) : 1;
  logic [2:0] state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d, id_q, id_d, pick_idx, next_ptr;
  logic [PW-1:0] poll_cnt_q, poll_cnt_d;
  logic wr_q, wr_d, pick_any, full, fin;
  logic [DATA_W-1:0] data_q, data_d, rsp_data_q, rsp_data_d, d_in_q, d_in_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [1:0] addr_q, addr_d;
  logic nic_en_q, nic_en_d, nic_en_wr_q, nic_en_wr_d;
  // a requester whose done is showing still has req high, so it must not win again
  rr_pick #(.N(N_REQ)) u_pick (
    .req_i(req & ~done_q),
    .ptr_i(rr_ptr_q),
    .idx_o(pick_idx),
    .any_o(pick_any)
  );
  assign full = d_out[DATA_W-1];
  assign next_ptr = id_q == IW'(N_REQ - 1) ? '0 : id_q + 1'b1;
  always_comb begin
    state_d = state_q;
    rr_ptr_d = rr_ptr_q;
    poll_cnt_d = poll_cnt_q;
    id_d = id_q;
    wr_d = wr_q;
    data_d = data_q;
    case (state_q)
      IDLE:
        if (pick_any) begin
          state_d = POLL;
          id_d = pick_idx;
          wr_d = req_wr[pick_idx];
          data_d = req_data[int'(pick_idx)*DATA_W +: DATA_W];
          poll_cnt_d = '0;
        end
      POLL: state_d = CHECK;
      CHECK:
        if (!req[id_q]) begin
          state_d = IDLE;
          rr_ptr_d = next_ptr;
        end else if (wr_q != full) begin
          state_d = wr_q ? WRITE : READ;
        end else if (poll_cnt_q == PW'(POLL_MAX - 1)) begin
          state_d = IDLE;
          rr_ptr_d = next_ptr;
        end else begin
          poll_cnt_d = poll_cnt_q + 1'b1;
          state_d = POLL;
        end
      READ: state_d = RDATA;
      WRITE, RDATA: begin
        state_d = IDLE;
        rr_ptr_d = next_ptr;
      end
      default: state_d = IDLE;
    endcase
  end
  // NIC outputs are registered, so they are derived from the state being entered
  assign fin = state_d == WRITE || state_q == RDATA;
  assign done_d = fin ? N_REQ'(1) << id_q : '0;
  assign nic_en_d = state_d == POLL || state_d == WRITE || state_d == READ;
  assign nic_en_wr_d = state_d == WRITE;
  assign addr_d = state_d == POLL ? (wr_d ? NIC_ADDR_OUT_STAT : NIC_ADDR_IN_STAT) :
                  state_d == WRITE ? NIC_ADDR_OUT_DATA :
                  state_d == READ ? NIC_ADDR_IN_DATA : addr_q;
  assign d_in_d = state_d == WRITE ? data_q : d_in_q;
  assign rsp_data_d = state_q == RDATA ? d_out : rsp_data_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rr_ptr_q <= '0;
      poll_cnt_q <= '0;
      id_q <= '0;
      wr_q <= 1'b0;
      data_q <= '0;
      done_q <= '0;
      rsp_data_q <= '0;
      addr_q <= '0;
      d_in_q <= '0;
      nic_en_q <= 1'b0;
      nic_en_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      poll_cnt_q <= poll_cnt_d;
      id_q <= id_d;
      wr_q <= wr_d;
      data_q <= data_d;
      done_q <= done_d;
      rsp_data_q <= rsp_data_d;
      addr_q <= addr_d;
      d_in_q <= d_in_d;
      nic_en_q <= nic_en_d;
      nic_en_wr_q <= nic_en_wr_d;
    end
  end
  assign done = done_q;
  assign rsp_data = rsp_data_q;
  assign busy = state_q != IDLE;
  assign addr = addr_q;
  assign d_in = d_in_q;
  assign nicEn = nic_en_q;
  assign nicEnWr = nic_en_wr_q;
endmodule

// File: tb/tb_cardinal_nic_arbiter.sv
// tb_cardinal_nic_arbiter: scoreboard bench with a behavioural NIC model
module tb_cardinal_nic_arbiter;
  import cardinal_nic_pkg::*;
  localparam int N = 4;
  localparam int W = 64;
  typedef struct {
    int id;
    bit wr;
    logic [W-1:0] data;
  } exp_t;
  logic clk, reset;
  logic [N-1:0] req, req_wr, done;
  logic [N*W-1:0] req_data;
  logic [W-1:0] rsp_data, d_in, d_out, in_data;
  logic busy, nicEn, nicEnWr, in_full, out_full;
  logic [1:0] addr;
  exp_t q[$];
  int checks = 0, errors = 0, rd_cnt = 0, stat_polls = 0;
  cardinal_nic_arbiter #(.N_REQ(N), .DATA_W(W), .POLL_MAX(2)) dut (
    .clk(clk), .reset(reset), .req(req), .req_wr(req_wr), .req_data(req_data),
    .done(done), .rsp_data(rsp_data), .busy(busy), .addr(addr), .d_in(d_in),
    .nicEn(nicEn), .nicEnWr(nicEnWr), .d_out(d_out)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk or negedge reset)
    if (!reset) d_out <= '0;
    else if (nicEn && !nicEnWr)
      d_out <= addr == 2'b00 ? in_data : addr == 2'b01 ? {in_full, 63'b0} :
               addr == 2'b11 ? {out_full, 63'b0} : '0;
  task automatic step();
    @(negedge clk);
  endtask
  task automatic push(input int id, input bit wr, input logic [W-1:0] data);
    exp_t e;
    e.id = id;
    e.wr = wr;
    e.data = data;
    q.push_back(e);
  endtask
  task automatic monitor();
    exp_t e;
    logic [N-1:0] want;
    forever begin
      @(negedge clk);
      if (reset && nicEn && !nicEnWr && addr == 2'b00) rd_cnt++;
      if (reset && nicEn && !nicEnWr && addr == 2'b11) stat_polls++;
      if (reset && (done != 0 || (nicEn && nicEnWr))) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done done=%b nicEnWr=%b", done, nicEnWr);
        end else begin
          e = q.pop_front();
          want = N'(1) << e.id;
          if (done !== want) begin
            errors++;
            $display("FAIL done_order got %b want %b", done, want);
          end else if (e.wr && !(nicEn && nicEnWr && addr == 2'b10 && d_in === e.data)) begin
            errors++;
            $display("FAIL nic_write en=%b wr=%b addr=%b d_in=%h want d_in=%h", nicEn, nicEnWr, addr, d_in, e.data);
          end else if (!e.wr && rsp_data !== e.data) begin
            errors++;
            $display("FAIL rsp_data got %h want %h", rsp_data, e.data);
          end
        end
        req = req & ~done;
      end
    end
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (q.size() == 0 && !busy) return;
      step();
    end
    checks++;
    errors++;
    $display("FAIL wait_idle timeout pending=%0d busy=%b", q.size(), busy);
  endtask
  task automatic set_req(input int i, input bit wr, input logic [W-1:0] data);
    req_wr[i] = wr;
    req_data[i*W +: W] = data;
    req[i] = 1'b1;
  endtask
  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    checks++;
    if ({busy, nicEn, nicEnWr, done, addr} !== '0 || rsp_data !== '0 || d_in !== '0) begin
      errors++;
      $display("FAIL reset_outputs busy=%b en=%b wr=%b done=%b addr=%b rsp=%h d_in=%h want all 0",
               busy, nicEn, nicEnWr, done, addr, rsp_data, d_in);
    end
    reset = 1'b1;
    step();
    checks++;
    if (dut.state_q !== IDLE || dut.rr_ptr_q !== 2'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state state=%0d rr_ptr=%0d busy=%b want 0 0 0", dut.state_q, dut.rr_ptr_q, busy);
    end
  endtask
  task automatic test_single_send();
    out_full = 1'b0;
    set_req(0, 1'b1, 64'h2);
    push(0, 1'b1, 64'h2);
    step();
    checks++;
    if (!(nicEn && !nicEnWr && addr == 2'b11 && busy)) begin
      errors++;
      $display("FAIL send_poll en=%b wr=%b addr=%b want 1 0 11", nicEn, nicEnWr, addr);
    end
    step();
    checks++;
    if (nicEn !== 1'b0) begin
      errors++;
      $display("FAIL send_check nicEn got %b want 0", nicEn);
    end
    step();
    checks++;
    if (done !== 4'b0001 || addr !== 2'b10 || nicEnWr !== 1'b1 || d_in !== 64'h2) begin
      errors++;
      $display("FAIL send_write done=%b addr=%b wr=%b d_in=%h want 0001 10 1 2", done, addr, nicEnWr, d_in);
    end
    wait_idle();
  endtask
  task automatic test_single_receive();
    in_full = 1'b1;
    in_data = 64'h1;
    set_req(2, 1'b0, '0);
    push(2, 1'b0, 64'h1);
    step();
    checks++;
    if (!(nicEn && addr == 2'b01)) begin
      errors++;
      $display("FAIL recv_poll en=%b addr=%b want 1 01", nicEn, addr);
    end
    step();
    step();
    checks++;
    if (!(nicEn && !nicEnWr && addr == 2'b00)) begin
      errors++;
      $display("FAIL recv_read en=%b wr=%b addr=%b want 1 0 00", nicEn, nicEnWr, addr);
    end
    step();
    step();
    checks++;
    if (done !== 4'b0100 || rsp_data !== 64'h1 || dut.rr_ptr_q !== 2'd3) begin
      errors++;
      $display("FAIL recv_done done=%b rsp=%h rr_ptr=%0d want 0100 1 3", done, rsp_data, dut.rr_ptr_q);
    end
    wait_idle();
    in_full = 1'b0;
  endtask
  task automatic test_full();
    int base;
    out_full = 1'b1;
    base = stat_polls;
    set_req(1, 1'b1, 64'hA1);
    set_req(2, 1'b1, 64'hB2);
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (stat_polls - base !== 2 || nicEnWr !== 1'b0) begin
      errors++;
      $display("FAIL full_polls got %0d want 2", stat_polls - base);
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL full_yield busy got %b want 0", busy);
    end
    step();
    checks++;
    if (dut.id_q !== 2'd2 || !nicEn || addr !== 2'b11) begin
      errors++;
      $display("FAIL full_next_grant id=%0d en=%b addr=%b want 2 1 11", dut.id_q, nicEn, addr);
    end
    out_full = 1'b0;
    push(2, 1'b1, 64'hB2);
    push(1, 1'b1, 64'hA1);
    wait_idle();
  endtask
  task automatic test_contention();
    int n;
    reset = 1'b0;
    step();
    reset = 1'b1;
    out_full = 1'b0;
    for (int i = 0; i < N; i++) begin
      set_req(i, 1'b1, 64'h10 + 64'(i));
      push(i, 1'b1, 64'h10 + 64'(i));
    end
    n = 0;
    while (q.size() > 3 && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (q.size() !== 3) begin
      errors++;
      $display("FAIL contention_first pending got %0d want 3", q.size());
    end
    set_req(0, 1'b1, 64'h50);
    push(0, 1'b1, 64'h50);
    wait_idle();
  endtask
  task automatic test_abort();
    int base;
    in_full = 1'b0;
    base = rd_cnt;
    set_req(3, 1'b0, '0);
    step();
    checks++;
    if (!(nicEn && addr == 2'b01)) begin
      errors++;
      $display("FAIL abort_poll en=%b addr=%b want 1 01", nicEn, addr);
    end
    req[3] = 1'b0;
    step();
    step();
    checks++;
    if (busy !== 1'b0 || rd_cnt !== base || dut.rr_ptr_q !== 2'd0) begin
      errors++;
      $display("FAIL abort busy=%b reads=%0d rr_ptr=%0d want 0 0 0", busy, rd_cnt - base, dut.rr_ptr_q);
    end
    step();
  endtask
  task automatic test_reset_mid_write();
    out_full = 1'b0;
    set_req(0, 1'b1, 64'hCAFE);
    push(0, 1'b1, 64'hCAFE);
    step();
    step();
    step();
    checks++;
    if (!(nicEn && nicEnWr && done == 4'b0001)) begin
      errors++;
      $display("FAIL rst_pre_write en=%b wr=%b done=%b want 1 1 0001", nicEn, nicEnWr, done);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({nicEn, nicEnWr, done, busy} !== '0) begin
      errors++;
      $display("FAIL rst_async en=%b wr=%b done=%b busy=%b want 0", nicEn, nicEnWr, done, busy);
    end
    req = '0;
    q.delete();
    step();
    reset = 1'b1;
    step();
    checks++;
    if (dut.state_q !== IDLE || dut.rr_ptr_q !== 2'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_release state=%0d rr_ptr=%0d busy=%b want 0 0 0", dut.state_q, dut.rr_ptr_q, busy);
    end
  endtask
  initial begin
    reset = 1'b0;
    req = '0;
    req_wr = '0;
    req_data = '0;
    in_data = '0;
    in_full = 1'b0;
    out_full = 1'b0;
    fork
      monitor();
    join_none
    test_reset();
    test_single_send();
    test_single_receive();
    test_full();
    test_contention();
    test_abort();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
